// File: rtl/arbitro_memoria_if.sv
// Bus bundle linking the fetch and load/store requesters, the memory arbiter and the unified memory.
interface arbitro_memoria_if #(
    parameter int LARGURA = 32
);
    // Handshake: a requester raises req with addr/we/wdata stable and holds them until its
    // one-cycle done pulse; rdata is valid from done until that port's next completion.
    // mem_en is a single-cycle strobe, mem_we is meaningful only while mem_en is high.
    logic               if_req;
    logic [LARGURA-1:0] if_addr;
    logic               if_done;
    logic [LARGURA-1:0] if_rdata;
    logic               dm_req;
    logic               dm_we;
    logic [LARGURA-1:0] dm_addr;
    logic [LARGURA-1:0] dm_wdata;
    logic               dm_done;
    logic [LARGURA-1:0] dm_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [LARGURA-1:0] mem_addr;
    logic [LARGURA-1:0] mem_wdata;
    logic [LARGURA-1:0] mem_rdata;
    logic               sel_endereco;
    logic               ocupado;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_done, if_rdata, dm_done, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, sel_endereco, ocupado
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_done, if_rdata, dm_done, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, sel_endereco, ocupado
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch (IF) and data access (DM).
module arbitro_memoria #(
    parameter int LARGURA      = 32,
    parameter int LATENCIA     = 1,
    parameter int MAX_SEGUIDAS = 2,
    localparam int CW = $clog2(MAX_SEGUIDAS + 1),
    localparam int LW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    arbitro_memoria_if.slave    bus,
    output logic [1:0]          estado_o,
    output logic [CW-1:0]       cont_dm_o
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        ESPERA   = 2'd2,
        RESPOSTA = 2'd3
    } estado_t;

    estado_t            estado_q, estado_d;
    logic               sel_q, sel_d;
    logic               we_q, we_d;
    logic [LARGURA-1:0] addr_q, addr_d;
    logic [LARGURA-1:0] wdata_q, wdata_d;
    logic [CW-1:0]      cont_q, cont_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic               if_done_q, if_done_d;
    logic               dm_done_q, dm_done_d;
    logic [LARGURA-1:0] if_rdata_q, if_rdata_d;
    logic [LARGURA-1:0] dm_rdata_q, dm_rdata_d;
    logic               concede_dm;

    always_comb begin
        estado_d   = estado_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cont_d     = cont_q;
        lat_d      = lat_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        concede_dm = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (bus.if_req || bus.dm_req) begin
                    // DM wins ties until it has taken MAX_SEGUIDAS grants in a row over a waiting IF
                    concede_dm = bus.dm_req && !(bus.if_req && cont_q == CW'(MAX_SEGUIDAS));
                    estado_d   = ACESSO;
                    sel_d      = concede_dm;
                    mem_en_d   = 1'b1;
                    if (concede_dm) begin
                        addr_d   = bus.dm_addr;
                        we_d     = bus.dm_we;
                        wdata_d  = bus.dm_wdata;
                        mem_we_d = bus.dm_we;
                        if (!bus.if_req)
                            cont_d = '0;
                        else if (cont_q != CW'(MAX_SEGUIDAS))
                            cont_d = cont_q + CW'(1);
                    end else begin
                        addr_d = bus.if_addr;
                        we_d   = 1'b0;
                        cont_d = '0;
                    end
                end
            end
            ACESSO: begin
                estado_d = ESPERA;
                lat_d    = LW'(LATENCIA - 1);
            end
            ESPERA: begin
                if (lat_q == '0) begin
                    if (!we_q) begin
                        if (sel_q) dm_rdata_d = bus.mem_rdata;
                        else       if_rdata_d = bus.mem_rdata;
                    end
                    if_done_d = !sel_q;
                    dm_done_d = sel_q;
                    estado_d  = RESPOSTA;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            RESPOSTA: estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cont_q     <= '0;
            lat_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            estado_q   <= estado_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cont_q     <= cont_d;
            lat_q      <= lat_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.sel_endereco = sel_q;
    assign bus.ocupado      = (estado_q != OCIOSO);
    assign bus.if_done      = if_done_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.dm_done      = dm_done_q;
    assign bus.dm_rdata     = dm_rdata_q;
    assign estado_o         = estado_q;
    assign cont_dm_o        = cont_q;

endmodule
